// File: rtl/debug_trace_pkg.sv
// -----------------------------------------------------------------------------
// debug_trace_pkg
// Shared definitions for the debug trace path.
// Contents:
//   - TRACE_W / TS_W / PAYLOAD_W : record geometry (32 = 2 kind + 14 ts + 16 payload)
//   - trace_kind_e               : record kind codes (2'b11 reserved, never emitted)
//   - CORE_* localparams         : core FSM state codes
//   - trace_rec_t                : packed record layout {kind, ts, payload}
//   - state_payload()            : packs the FSM tuple into a STATE payload
// -----------------------------------------------------------------------------
package debug_trace_pkg;

  localparam int TRACE_W   = 32;
  localparam int TS_W      = 14;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    STATE = 2'b00,
    INSTR = 2'b01,
    DROP  = 2'b10
  } trace_kind_e;

  localparam logic [2:0] CORE_IDLE    = 3'd0;
  localparam logic [2:0] CORE_FETCH   = 3'd1;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'd3;
  localparam logic [2:0] CORE_WAIT    = 3'd4;
  localparam logic [2:0] CORE_EXECUTE = 3'd5;
  localparam logic [2:0] CORE_UPDATE  = 3'd6;
  localparam logic [2:0] CORE_DONE    = 3'd7;

  typedef struct packed {
    trace_kind_e            kind;
    logic [TS_W-1:0]        ts;
    logic [PAYLOAD_W-1:0]   payload;
  } trace_rec_t;

  function automatic logic [PAYLOAD_W-1:0] state_payload(
    input logic [2:0] core,
    input logic [2:0] fetch,
    input logic [1:0] lsu,
    input logic [2:0] memctrl
  );
    return {core, fetch, lsu, memctrl, 5'b0};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Show-ahead FIFO holding trace records. The head slot is visible on 'head'
// whenever 'valid' is high; a pop happens on valid && ready.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-low reset (empties the FIFO)
//   push       in   write push_data this cycle (ignored when full)
//   push_data  in   WIDTH record to store
//   ready      in   consumer accepts the head record
//   valid      out  FIFO non-empty
//   head       out  head record (zero when empty)
//   level      out  occupied slots, 0..DEPTH
//   full       out  level == DEPTH
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             wr;
  logic             rd;

  assign full  = (count == LW'(DEPTH));
  assign valid = (count != '0);
  assign wr    = push && !full;
  assign rd    = ready && valid;
  assign level = count;
  // Empty FIFO presents zero so the output is clean after reset.
  assign head  = valid ? mem[rd_ptr] : '0;

  // Storage carries no reset; only slots already written are ever read.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_trace_encoder.sv
// -----------------------------------------------------------------------------
// core_trace_encoder
// Watches one core's FSM state tuple (core, fetcher, LSU, memory controller)
// and emits a timestamped 32-bit record each time the tuple changes or tracing
// is (re)enabled. Records queue in a show-ahead FIFO and stream out over
// valid/ready. Records that find the FIFO full are counted and reported later
// as a single DROP record.
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-low reset
//   trace_enable   in   record generation enable
//   core_state     in   core FSM code
//   fetcher_state  in   fetcher FSM code
//   lsu_state      in   LSU FSM code
//   memctrl_state  in   memory controller FSM code
//   instruction    in   core instruction register
//   trace_valid    out  record available
//   trace_data     out  record {kind[31:30], ts[29:16], payload[15:0]}
//   trace_ready    in   sink accepts record
//   fifo_level     out  occupied FIFO slots
//   drop_pending   out  drop counter nonzero
// -----------------------------------------------------------------------------
module core_trace_encoder
  import debug_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trace_enable,
  input  logic [2:0]                    core_state,
  input  logic [2:0]                    fetcher_state,
  input  logic [1:0]                    lsu_state,
  input  logic [2:0]                    memctrl_state,
  input  logic [15:0]                   instruction,
  output logic                          trace_valid,
  output logic [TRACE_W-1:0]            trace_data,
  input  logic                          trace_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_pending
);

  logic [10:0]          tuple;
  logic [10:0]          prev_tuple;
  logic                 prev_enable;
  logic [TS_WIDTH-1:0]  ts;
  logic [15:0]          drop_count;
  logic                 fifo_full;
  logic                 event_hit;
  logic                 flush;
  logic                 push;
  trace_rec_t           push_rec;

  assign tuple = {core_state, fetcher_state, lsu_state, memctrl_state};

  // A rising enable forces a record even when the tuple is unchanged, so
  // the sink always learns the current state when tracing starts.
  assign event_hit = trace_enable && ((tuple != prev_tuple) || !prev_enable);

  // The DROP record only goes out on an edge with no event, so a burst of
  // events always wins the single push slot.
  assign flush = !event_hit && !fifo_full && (drop_count != 16'd0);

  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    if (event_hit) begin
      push       = !fifo_full;
      push_rec.ts = ts;
      if (core_state == CORE_DECODE) begin
        push_rec.kind    = INSTR;
        push_rec.payload = instruction;
      end else begin
        push_rec.kind    = STATE;
        push_rec.payload = state_payload(core_state, fetcher_state, lsu_state, memctrl_state);
      end
    end else if (flush) begin
      push             = 1'b1;
      push_rec.kind    = DROP;
      push_rec.ts      = ts;
      push_rec.payload = drop_count;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts          <= '0;
      prev_tuple  <= '0;
      prev_enable <= 1'b0;
      drop_count  <= '0;
    end else begin
      ts          <= ts + 1'b1;
      prev_tuple  <= tuple;
      prev_enable <= trace_enable;
      if (event_hit && fifo_full) begin
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end else if (flush) begin
        drop_count <= '0;
      end
    end
  end

  assign drop_pending = (drop_count != 16'd0);

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .ready     (trace_ready),
    .valid     (trace_valid),
    .head      (trace_data),
    .level     (fifo_level),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_core_trace_encoder.sv
// -----------------------------------------------------------------------------
// tb_core_trace_encoder
// Directed and randomized checks of core_trace_encoder (FIFO_DEPTH=4) against
// a queue-based reference model of the record stream.
// -----------------------------------------------------------------------------
module tb_core_trace_encoder;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          trace_enable = 1'b0;
  logic          trace_ready = 1'b0;
  logic [2:0]    core_state = '0;
  logic [2:0]    fetcher_state = '0;
  logic [1:0]    lsu_state = '0;
  logic [2:0]    memctrl_state = '0;
  logic [15:0]   instruction = '0;
  logic          trace_valid;
  logic [31:0]   trace_data;
  logic [LW-1:0] fifo_level;
  logic          drop_pending;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [13:0] m_ts;
  logic [15:0] m_drop;
  logic [10:0] m_prev;
  logic        m_prev_en;

  always #5 clk = ~clk;

  core_trace_encoder #(
    .FIFO_DEPTH (DEPTH),
    .TS_WIDTH   (14)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trace_enable  (trace_enable),
    .core_state    (core_state),
    .fetcher_state (fetcher_state),
    .lsu_state     (lsu_state),
    .memctrl_state (memctrl_state),
    .instruction   (instruction),
    .trace_valid   (trace_valid),
    .trace_data    (trace_data),
    .trace_ready   (trace_ready),
    .fifo_level    (fifo_level),
    .drop_pending  (drop_pending)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts      = '0;
    m_drop    = '0;
    m_prev    = '0;
    m_prev_en = 1'b0;
  endtask

  // One clock edge of the record stream, from the rules directly.
  task automatic model_edge();
    logic [10:0] tup;
    bit ev;
    bit full;
    tup  = {core_state, fetcher_state, lsu_state, memctrl_state};
    ev   = trace_enable && ((tup != m_prev) || !m_prev_en);
    full = (mq.size() == DEPTH);
    if (mq.size() != 0 && trace_ready) begin
      $display("pop rec=%08h ts=%0d", mq[0], m_ts);
      void'(mq.pop_front());
    end
    if (ev) begin
      if (full) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else if (core_state == 3'd2) begin
        mq.push_back({2'b01, m_ts, instruction});
      end else begin
        mq.push_back({2'b00, m_ts, core_state, fetcher_state, lsu_state, memctrl_state, 5'b0});
      end
    end else if (!full && m_drop != 16'd0) begin
      mq.push_back({2'b10, m_ts, m_drop});
      m_drop = '0;
    end
    m_ts      = m_ts + 14'd1;
    m_prev    = tup;
    m_prev_en = trace_enable;
  endtask

  task automatic check_all();
    logic [31:0] exp_head;
    exp_head = (mq.size() != 0) ? mq[0] : 32'h0;
    chk("valid", 32'(trace_valid), 32'(mq.size() != 0));
    chk("data", trace_data, exp_head);
    chk("level", 32'(fifo_level), 32'(mq.size()));
    chk("drop_pending", 32'(drop_pending), 32'(m_drop != 16'd0));
  endtask

  task automatic step();
    bit          st;
    logic [31:0] sd;
    st = trace_valid && !trace_ready;
    sd = trace_data;
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check_all();
    if (st && reset) begin
      chk("hold_valid", 32'(trace_valid), 32'd1);
      chk("hold_data", trace_data, sd);
    end
  endtask

  initial begin
    model_reset();
    trace_ready = 1'b1;

    // Reset held, then released with static inputs
    repeat (3) @(negedge clk);
    check_all();
    chk("rst_data", trace_data, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_valid", 32'(trace_valid), 32'd0);
      chk("idle_level", 32'(fifo_level), 32'd0);
    end

    // Fresh reset so timestamps line up with ts=0 on the first edge
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    trace_enable = 1'b1;
    step();                                        // ts=0: enable rise
    chk("first_rec", trace_data, 32'h0000_0000);
    chk("first_level", 32'(fifo_level), 32'd1);
    repeat (4) step();                             // ts=1..4, static
    chk("one_record", 32'(fifo_level), 32'd0);
    core_state = 3'd1;
    step();                                        // ts=5
    chk("state_rec", trace_data, 32'h0005_2000);
    repeat (3) step();                             // ts=6..8
    core_state  = 3'd2;
    instruction = 16'h3123;
    step();                                        // ts=9
    chk("instr_rec", trace_data, 32'h4009_3123);
    repeat (3) step();

    // Overflow: 6 events into 4 slots, then drain with DROP record
    trace_ready = 1'b0;
    core_state  = 3'd3;
    for (int f = 1; f <= 6; f++) begin
      fetcher_state = 3'(f);
      step();
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_drop_pending", 32'(drop_pending), 32'd1);
    trace_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", 32'({trace_data[31:30], trace_data[15:0]}),
          32'({2'b00, 3'd3, 3'(k + 1), 2'b00, 3'b000, 5'b0}));
      step();
    end
    chk("drop_rec", 32'({trace_data[31:30], trace_data[15:0]}), 32'({2'b10, 16'h0002}));
    chk("drop_cleared", 32'(drop_pending), 32'd0);
    step();

    // Randomized traffic with bursty back-pressure
    for (int i = 0; i < 3000; i++) begin
      trace_ready  = ($urandom_range(0, 99) < ((i < 1500) ? 30 : 80));
      trace_enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) == 0) begin
        core_state    = 3'($urandom_range(0, 7));
        fetcher_state = 3'($urandom_range(0, 7));
        lsu_state     = 2'($urandom_range(0, 3));
        memctrl_state = 3'($urandom_range(0, 7));
        instruction   = 16'($urandom_range(0, 65535));
      end
      step();
    end

    // Reset mid-stream with level=3 and a drop pending
    trace_enable = 1'b0;
    trace_ready  = 1'b1;
    repeat (8) step();
    trace_enable  = 1'b1;
    trace_ready   = 1'b0;
    core_state    = 3'd4;
    lsu_state     = 2'd0;
    memctrl_state = 3'd0;
    for (int f = 1; f <= 6; f++) begin
      fetcher_state = 3'(f);
      step();
    end
    trace_ready = 1'b1;
    step();
    chk("mid_level", 32'(fifo_level), 32'd3);
    chk("mid_drop_pending", 32'(drop_pending), 32'd1);
    trace_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(trace_valid), 32'd0);
    chk("async_level", 32'(fifo_level), 32'd0);
    chk("async_data", trace_data, 32'h0);
    chk("async_drop", 32'(drop_pending), 32'd0);
    model_reset();
    repeat (2) step();
    @(negedge clk);
    reset         = 1'b1;
    trace_ready   = 1'b1;
    core_state    = 3'd1;
    fetcher_state = 3'd0;
    step();
    chk("ts_restart", trace_data, 32'h0000_2000);

    // Timestamp wrap 0x3FFF -> 0
    trace_enable = 1'b0;
    for (int i = 0; i < 20000 && m_ts != 14'h3FFF; i++) step();
    trace_enable = 1'b1;
    core_state   = 3'd5;
    step();
    chk("wrap_hi_ts", 32'(trace_data[29:16]), 32'h3FFF);
    core_state = 3'd6;
    step();
    chk("wrap_lo_ts", 32'(trace_data[29:16]), 32'h0);
    chk("wrap_lo_rec", trace_data, 32'h0000_C000);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
